step_repeat_controller: RTL and testbench

//   Turns the raw front-panel UP/DOWN buttons into clean one-cycle up/down strobes
//   for the 0..2000 frequency-step counter. One step per press; auto-repeat after a hold

---
 rtl/step_repeat_controller_pkg.sv | 47 ++++
 rtl/step_repeat_controller_debouncer.sv | 48 ++++
 rtl/step_repeat_controller.sv | 130 +++++++++++++
 tb/tb_step_repeat_controller.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/step_repeat_controller_pkg.sv
// Shared types, default timing and helpers for the step/repeat button controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package step_repeat_controller_pkg;

  // Controller FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRESS  = 2'd1,
    ST_HOLD   = 2'd2,
    ST_REPEAT = 2'd3
  } state_t;

  // Requested step direction after debouncing
  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DN   = 2'd2
  } dir_t;

  // Default timing at a 50 MHz clock
  localparam int unsigned DEF_DEBOUNCE_CYCLES    = 50000;
  localparam int unsigned DEF_HOLD_CYCLES        = 25000000;
  localparam int unsigned DEF_REPEAT_CYCLES      = 2500000;
  localparam int unsigned DEF_FAST_REPEAT_CYCLES = 250000;
  localparam int unsigned DEF_FAST_AFTER         = 10;

  // Bits needed to hold any value 0..max_val
  function automatic int unsigned width_for(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Exactly one button held means a direction; both or neither means none
  function automatic dir_t decode_dir(input logic deb_up, input logic deb_dn);
    if (deb_up && !deb_dn) return DIR_UP;
    if (deb_dn && !deb_up) return DIR_DN;
    return DIR_NONE;
  endfunction

endpackage

// File: rtl/step_repeat_controller_debouncer.sv
// Two-flop synchronizer followed by a stability counter for one raw button.
// Latency: level follows raw 2 + DEBOUNCE_CYCLES cycles after raw settles.
// Backpressure: none; free-running on every clock.
module button_debouncer
  import step_repeat_controller_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int unsigned CW = width_for(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_a;
  logic          sync_b;
  logic [CW-1:0] cnt;

  // Bring the asynchronous pad level into the clock domain
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles in a row
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync_b == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      level <= sync_b;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/step_repeat_controller.sv
// Front-panel UP/DOWN buttons to one-cycle step strobes with hold-to-repeat and acceleration.
// Latency: first strobe 2 + DEBOUNCE_CYCLES + 1 cycles after raw settles (+1 if leaving HOLD/REPEAT).
// Backpressure: none; strobes are issued unconditionally.
module step_repeat_controller
  import step_repeat_controller_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES    = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES        = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES      = DEF_REPEAT_CYCLES,
  parameter int unsigned FAST_REPEAT_CYCLES = DEF_FAST_REPEAT_CYCLES,
  parameter int unsigned FAST_AFTER         = DEF_FAST_AFTER
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up_raw,
  input  logic btn_down_raw,
  output logic up,
  output logic down,
  output logic repeating,
  output logic fast
);

  localparam int unsigned TW = width_for(max3(HOLD_CYCLES, REPEAT_CYCLES, FAST_REPEAT_CYCLES));
  localparam int unsigned RW = width_for(FAST_AFTER);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] SLOW_LAST = TW'(REPEAT_CYCLES - 1);
  localparam logic [TW-1:0] FAST_LAST = TW'(FAST_REPEAT_CYCLES - 1);
  localparam logic [RW-1:0] REP_SAT   = RW'(FAST_AFTER);

  logic          deb_up;
  logic          deb_dn;
  dir_t          cur_dir;
  logic          same_dir;
  logic          at_fast;
  logic [TW-1:0] period_last;

  state_t        state, state_n;
  dir_t          dir_lat, dir_n;
  logic [TW-1:0] timer, timer_n;
  logic [RW-1:0] rep_cnt, rep_n;
  logic          strobe;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_up_raw),
    .level (deb_up)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dn (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_down_raw),
    .level (deb_dn)
  );

  assign cur_dir     = decode_dir(deb_up, deb_dn);
  // Any change (release, opposite button, both held) aborts the current press
  assign same_dir    = (cur_dir == dir_lat);
  assign at_fast     = (rep_cnt == REP_SAT);
  assign period_last = at_fast ? FAST_LAST : SLOW_LAST;

  // State, timer, repeat count and latched direction registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      dir_lat <= DIR_NONE;
      timer   <= '0;
      rep_cnt <= '0;
    end else begin
      state   <= state_n;
      dir_lat <= dir_n;
      timer   <= timer_n;
      rep_cnt <= rep_n;
    end
  end

  // Next-state logic and strobe/status decode
  always_comb begin
    state_n   = state;
    dir_n     = dir_lat;
    timer_n   = timer;
    rep_n     = rep_cnt;
    strobe    = 1'b0;
    repeating = 1'b0;
    fast      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cur_dir != DIR_NONE) begin
          state_n = ST_PRESS;
          dir_n   = cur_dir;
        end
      end
      ST_PRESS: begin
        strobe  = 1'b1;
        timer_n = '0;
        state_n = ST_HOLD;
      end
      ST_HOLD: begin
        if (!same_dir) begin
          state_n = ST_IDLE;
        end else if (timer == HOLD_LAST) begin
          state_n = ST_REPEAT;
          timer_n = '0;
          rep_n   = '0;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      ST_REPEAT: begin
        repeating = 1'b1;
        fast      = at_fast;
        if (!same_dir) begin
          state_n = ST_IDLE;
        end else if (timer == period_last) begin
          strobe  = 1'b1;
          timer_n = '0;
          if (!at_fast) rep_n = rep_cnt + 1'b1;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign up   = strobe && (dir_lat == DIR_UP);
  assign down = strobe && (dir_lat == DIR_DN);

endmodule

// File: tb/tb_step_repeat_controller.sv
module tb_step_repeat_controller;

  localparam int DEB  = 4;
  localparam int HOLD = 20;
  localparam int REP  = 8;
  localparam int FREP = 2;
  localparam int FA   = 3;
  // Raw edge to first strobe
  localparam int LAT  = 2 + DEB + 1;
  // Cycles after a raw release during which the debounced level still reads pressed
  localparam int TAIL = DEB + 1;

  logic clk          = 1'b0;
  logic reset        = 1'b0;
  logic btn_up_raw   = 1'b0;
  logic btn_down_raw = 1'b0;
  logic up, down, repeating, fast;

  typedef struct {
    int cyc;
    bit is_up;
    bit rep;
    bit fst;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   n_strobes = 0;
  int   cyc       = 0;

  step_repeat_controller #(
    .DEBOUNCE_CYCLES    (DEB),
    .HOLD_CYCLES        (HOLD),
    .REPEAT_CYCLES      (REP),
    .FAST_REPEAT_CYCLES (FREP),
    .FAST_AFTER         (FA)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_up_raw   (btn_up_raw),
    .btn_down_raw (btn_down_raw),
    .up           (up),
    .down         (down),
    .repeating    (repeating),
    .fast         (fast)
  );

  always #5 clk = ~clk;

  // Cycle n is the interval following the n-th rising edge
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every strobe must match the oldest expected entry
  always @(negedge clk) begin
    n_checks++;
    if ((up & down) !== 1'b0) begin
      n_fail++;
      $display("FAIL up_down_exclusive cycle %0d: up=%b down=%b, required not both high", cyc, up, down);
    end
    if (up === 1'b1 || down === 1'b1) begin
      n_strobes++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe cycle %0d: up=%b down=%b, required no strobe", cyc, up, down);
      end else begin
        mon_e = exp_q.pop_front();
        if (cyc !== mon_e.cyc || up !== mon_e.is_up || down !== !mon_e.is_up ||
            repeating !== mon_e.rep || fast !== mon_e.fst) begin
          n_fail++;
          $display("FAIL strobe got cycle=%0d up=%b down=%b rep=%b fast=%b, required cycle=%0d up=%b down=%b rep=%b fast=%b",
                   cyc, up, down, repeating, fast,
                   mon_e.cyc, mon_e.is_up, !mon_e.is_up, mon_e.rep, mon_e.fst);
        end
      end
    end
  end

  task automatic push(input int c, input bit u, input bit r, input bit f);
    exp_t e;
    e.cyc   = c;
    e.is_up = u;
    e.rep   = r;
    e.fst   = f;
    exp_q.push_back(e);
  endtask

  // Expected strobes for a press whose raw edge is in cycle s and whose
  // debounced level stays in the same direction through cycle last
  task automatic sched(input int s, input int last, input bit is_up);
    int t, p, k;
    if (s + LAT <= last) push(s + LAT, is_up, 1'b0, 1'b0);
    t = s + LAT + 1 + HOLD;
    k = 0;
    p = REP;
    while (t + p - 1 <= last) begin
      push(t + p - 1, is_up, 1'b1, (k == FA));
      t = t + p;
      if (k < FA) k++;
      p = (k < FA) ? REP : FREP;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset      = 1'b0;
    btn_up_raw = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if ({up, down, repeating, fast} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: up/down/repeating/fast=%b, required 0000",
                 cyc, {up, down, repeating, fast});
      end
    end
    btn_up_raw = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(15);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_pending got %0d outstanding strobes, required 0", exp_q.size());
    end
  endtask

  task automatic test_bounce();
    int s0;
    s0 = n_strobes;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      btn_up_raw = !btn_up_raw;
      @(negedge clk);
    end
    btn_up_raw = 1'b0;
    tick(20);
    n_checks++;
    if (n_strobes - s0 != 0) begin
      n_fail++;
      $display("FAIL bounce_strobes got %0d, required 0", n_strobes - s0);
    end
  endtask

  task automatic test_short_press();
    int s, s0;
    s0 = n_strobes;
    @(negedge clk);
    btn_up_raw = 1'b1;
    s = cyc;
    sched(s, s + 15 + TAIL, 1'b1);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      n_checks++;
      if (repeating !== 1'b0) begin
        n_fail++;
        $display("FAIL short_repeating cycle %0d: got %b, required 0", cyc, repeating);
      end
    end
    btn_up_raw = 1'b0;
    tick(30);
    n_checks++;
    if (n_strobes - s0 != 1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL short_count got %0d strobes (%0d outstanding), required 1 (0)",
               n_strobes - s0, exp_q.size());
    end
  endtask

  task automatic test_long_hold();
    int s, r;
    @(negedge clk);
    btn_down_raw = 1'b1;
    s = cyc;
    sched(s, s + 80 + TAIL, 1'b0);
    tick(80);
    btn_down_raw = 1'b0;
    r = cyc;
    tick(7);
    n_checks++;
    if (repeating !== 1'b0 || fast !== 1'b0 || cyc != r + 7) begin
      n_fail++;
      $display("FAIL long_release cycle %0d: repeating=%b fast=%b, required 0 0 at cycle %0d",
               cyc, repeating, fast, r + 7);
    end
    tick(30);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL long_pending got %0d outstanding strobes, required 0", exp_q.size());
    end
  endtask

  task automatic test_both_pressed();
    int s, d, u;
    @(negedge clk);
    btn_up_raw = 1'b1;
    s = cyc;
    d = s + 40;
    u = d + 20;
    sched(s, d + TAIL, 1'b1);
    sched(u, u + 10 + TAIL, 1'b0);
    tick(40);
    btn_down_raw = 1'b1;
    tick(20);
    btn_up_raw = 1'b0;
    tick(10);
    btn_down_raw = 1'b0;
    tick(30);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL both_pending got %0d outstanding strobes, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_repeat();
    int s, x;
    @(negedge clk);
    btn_up_raw = 1'b1;
    s = cyc;
    x = s + 60;
    sched(s, x, 1'b1);
    sched(x + 1, x + 11 + TAIL, 1'b1);
    tick(60);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({up, down, repeating, fast} !== 4'b0000) begin
      n_fail++;
      $display("FAIL midreset_outputs cycle %0d: up/down/repeating/fast=%b, required 0000",
               cyc, {up, down, repeating, fast});
    end
    reset = 1'b1;
    tick(10);
    btn_up_raw = 1'b0;
    tick(30);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL midreset_pending got %0d outstanding strobes, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_short_press();
    test_long_hold();
    test_both_pressed();
    test_reset_mid_repeat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
